// File: rtl/i2s_tx_stream.sv
// rtl/i2s_tx_stream.sv - stereo I2S transmitter with valid/ready sample input
// Optional build macro I2S_TX_LJ_MODE_EN selects left-justified data alignment.
module i2s_tx_stream #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_W    = 32,
    parameter int MCLK_HALF = 2,
    parameter int SCK_HALF  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                mclk,
    output logic                sck,
    output logic                lrck,
    output logic                sdout,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int BW    = $clog2(FRAME);
    localparam int MW    = $clog2(MCLK_HALF + 1);
    localparam int SW    = $clog2(SCK_HALF + 1);

    logic [MW-1:0]       mclk_cnt;
    logic [SW-1:0]       sck_cnt;
    logic [BW-1:0]       bitpos;
    logic                full;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] smp_l, smp_r;

    logic                mclk_wrap, sck_wrap, fall, load, accept;
    logic [BW-1:0]       bitpos_nx;
    logic                lr_nx, sd_nx;
    logic [SAMPLE_W-1:0] ld_l, ld_r, word;
    int                  slot_k, bit_idx;

    assign mclk_wrap = (mclk_cnt == MW'(MCLK_HALF - 1));
    assign sck_wrap  = (sck_cnt == SW'(SCK_HALF - 1));
    assign fall      = sck_wrap && sck;
    assign s_ready   = ~full;
    assign accept    = s_valid && ~full;

    // Data for the slot being entered is taken from the post-load sample, so
    // a left-justified MSB can leave on the very edge that loads the frame.
    always_comb begin
        bitpos_nx = (bitpos == BW'(FRAME - 1)) ? '0 : bitpos + 1'b1;
        load      = fall && (bitpos_nx == '0);
        ld_l      = full ? hold_l : '0;
        ld_r      = full ? hold_r : '0;
        lr_nx     = (bitpos_nx >= BW'(SLOT_W));
        slot_k    = int'(bitpos_nx) % SLOT_W;
        if (lr_nx)
            word = smp_r;
        else
            word = load ? ld_l : smp_l;
`ifdef I2S_TX_LJ_MODE_EN
        bit_idx = (slot_k < SAMPLE_W) ? SAMPLE_W - 1 - slot_k : -1;
`else
        bit_idx = (slot_k >= 1 && slot_k <= SAMPLE_W) ? SAMPLE_W - slot_k : -1;
`endif
        sd_nx = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (i == bit_idx)
                sd_nx = word[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_cnt    <= '0;
            sck_cnt     <= '0;
            mclk        <= 1'b0;
            sck         <= 1'b1;
            lrck        <= 1'b0;
            sdout       <= 1'b0;
            bitpos      <= BW'(FRAME - 1);
            full        <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            smp_l       <= '0;
            smp_r       <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            mclk_cnt    <= mclk_wrap ? '0 : mclk_cnt + 1'b1;
            sck_cnt     <= sck_wrap ? '0 : sck_cnt + 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (mclk_wrap)
                mclk <= ~mclk;
            if (sck_wrap)
                sck <= ~sck;
            if (fall) begin
                bitpos <= bitpos_nx;
                lrck   <= lr_nx;
                sdout  <= sd_nx;
            end
            if (load) begin
                smp_l       <= ld_l;
                smp_r       <= ld_r;
                frame_start <= 1'b1;
                underrun    <= ~full;
            end
            // An accept can only coincide with an empty-register (underrun) load.
            if (accept) begin
                hold_l <= s_left;
                hold_r <= s_right;
                full   <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_stream.sv
// tb/tb_i2s_tx_stream.sv - randomized self-checking bench for i2s_tx_stream
module tb_i2s_tx_stream;

    localparam int SW    = 16;
    localparam int SLW   = 32;
    localparam int MH    = 2;
    localparam int SH    = 8;
    localparam int FRAME = 2 * SLW;
`ifdef I2S_TX_LJ_MODE_EN
    localparam logic [63:0] PAT = {16'hA5C3, 16'h0000, 16'h8001, 16'h0000};
`else
    localparam logic [63:0] PAT = {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h8001, 15'h0};
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic          mclk, sck, lrck, sdout, frame_start, underrun;

    i2s_tx_stream #(
        .SAMPLE_W (SW),
        .SLOT_W   (SLW),
        .MCLK_HALF(MH),
        .SCK_HALF (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .mclk       (mclk),
        .sck        (sck),
        .lrck       (lrck),
        .sdout      (sdout),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: time-based clock model plus frame/holding-register bookkeeping.
    int            t;
    int            m_bp;
    bit            m_full;
    logic [SW-1:0] m_hl, m_hr, m_cl, m_cr;
    bit            e_lr, e_sd, e_fs, e_ur;
    logic [63:0]   cap = '0;
    bit            dir_tag = 1'b0;
    logic [31:0]   q[$];

    function automatic bit bit_of(input logic [SW-1:0] w, input int bp);
        int k;
        int idx;
        k = bp % SLW;
`ifdef I2S_TX_LJ_MODE_EN
        idx = (k < SW) ? SW - 1 - k : -1;
`else
        idx = (k >= 1 && k <= SW) ? SW - k : -1;
`endif
        if (idx < 0)
            return 1'b0;
        return ((w >> idx) & 16'd1) != 16'd0;
    endfunction

    task automatic model_edge();
        bit acc;
        e_fs = 1'b0;
        e_ur = 1'b0;
        if (rst) begin
            t = 0; m_bp = FRAME - 1; m_full = 1'b0;
            m_cl = '0; m_cr = '0; e_lr = 1'b0; e_sd = 1'b0; dir_tag = 1'b0;
            return;
        end
        t++;
        acc = s_valid && !m_full;
        if (t % (2 * SH) == SH) begin
            m_bp = (m_bp + 1) % FRAME;
            if (m_bp == 0) begin
                if (dir_tag)
                    check("frame_bits", cap, PAT);
                e_fs = 1'b1;
                e_ur = !m_full;
                m_cl = m_full ? m_hl : '0;
                m_cr = m_full ? m_hr : '0;
                dir_tag = m_full && ({m_hl, m_hr} == 32'hA5C38001);
                m_full = 1'b0;
            end
            e_lr = (m_bp >= SLW);
            e_sd = bit_of(e_lr ? m_cr : m_cl, m_bp);
        end
        if (acc) begin
            m_hl = s_left;
            m_hr = s_right;
            m_full = 1'b1;
            void'(q.pop_front());
        end
    endtask

    task automatic compare();
        check("mclk", 64'(mclk), 64'((t / MH) % 2));
        check("sck", 64'(sck), 64'(1 - (t / SH) % 2));
        check("lrck", 64'(lrck), 64'(e_lr));
        check("sdout", 64'(sdout), 64'(e_sd));
        check("s_ready", 64'(s_ready), 64'(!m_full));
        check("frame_start", 64'(frame_start), 64'(e_fs));
        check("underrun", 64'(underrun), 64'(e_ur));
        if (t > 0 && t % (2 * SH) == 0)
            cap = {cap[62:0], sdout};
    endtask

    task automatic drive();
        s_valid = (q.size() > 0);
        if (q.size() > 0)
            {s_left, s_right} = q[0];
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare();
            drive();
        end
    endtask

    initial begin
        bit reached;
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        q.push_back(32'hA5C38001);
        drive();
        run(2100);
        run(3 * 1024);
        q.push_back($urandom);
        q.push_back($urandom);
        drive();
        run(3 * 1024);
        for (int i = 0; i < 6000; i++) begin
            if (q.size() < 3 && $urandom_range(699) == 0)
                q.push_back($urandom);
            run(1);
        end
        reached = 1'b0;
        for (int i = 0; i < 4000 && !reached; i++) begin
            if (q.size() == 0 && !m_full)
                q.push_back($urandom);
            drive();
            run(1);
            reached = m_full && (m_bp >= SLW + 8) && (q.size() == 0);
        end
        check("reach_right_slot", 64'(reached), 64'd1);
        rst = 1'b1;
        drive();
        run(1);
        rst = 1'b0;
        run(2100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
